// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported register file with byte-lane writes, optional
// write-to-read forwarding and a per-register pending (scoreboard) bit.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   d                write data (WIDTH)
//   w_sel, w_en      write address and enable
//   w_be             byte-lane write enables, bit i covers d[8i+7:8i]
//   a_sel, b_sel     read addresses for ports A and B
//   a, b             combinational read data
//   a_ready, b_ready selected register has no pending reservation
//   rsv_en, rsv_sel  reservation request and target register
//   clr              synchronous clear of all registers and reservations
//   pend_cnt         registered count of pending registers
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     d,
    input  logic [ADDR_W-1:0]    w_sel,
    input  logic                 w_en,
    input  logic [WIDTH/8-1:0]   w_be,
    input  logic [ADDR_W-1:0]    a_sel,
    input  logic [ADDR_W-1:0]    b_sel,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 a_ready,
    output logic                 b_ready,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_sel,
    input  logic                 clr,
    output logic [ADDR_W:0]      pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / 8;
    localparam int CW    = ADDR_W + 1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] be_mask;
    logic             wr_ok;
    logic             rsv_ok;

    // Byte enables widened to a bit mask for merging.
    always_comb begin
        be_mask = '0;
        for (int unsigned l = 0; l < NB; l++) begin
            be_mask[8*l +: 8] = {8{w_be[l]}};
        end
    end

    // Writes/reservations to register 0 are dropped when it is hardwired.
    always_comb begin
        wr_ok  = w_en   && !((ZERO_REG != 0) && (w_sel   == '0));
        rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_sel == '0));
    end

    // Clear before set so a same-edge write and reservation leaves the
    // register pending. A write clears pending regardless of w_be.
    always_comb begin
        pend_nxt = pend;
        if (w_en) begin
            pend_nxt[w_sel] = 1'b0;
        end
        if (rsv_ok) begin
            pend_nxt[rsv_sel] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[w_sel] <= (regs[w_sel] & ~be_mask) | (d & be_mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else if (clr) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Read ports: stored value, optionally merged with the in-flight write.
    logic [WIDTH-1:0] a_stored;
    logic [WIDTH-1:0] b_stored;
    logic             a_hit;
    logic             b_hit;

    always_comb begin
        a_stored = ((ZERO_REG != 0) && (a_sel == '0)) ? '0 : regs[a_sel];
        b_stored = ((ZERO_REG != 0) && (b_sel == '0)) ? '0 : regs[b_sel];
        a_hit    = (BYPASS != 0) && w_en && (w_sel == a_sel);
        b_hit    = (BYPASS != 0) && w_en && (w_sel == b_sel);

        a = a_stored;
        b = b_stored;
        if (a_hit && wr_ok) begin
            a = (a_stored & ~be_mask) | (d & be_mask);
        end
        if (b_hit && wr_ok) begin
            b = (b_stored & ~be_mask) | (d & be_mask);
        end

        a_ready = !pend[a_sel] || a_hit;
        b_ready = !pend[b_sel] || b_hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. Two instances (forwarding
// on and off) share stimulus; a behavioural model predicts every output.
module tb_regfile_sb;

    logic        clk;
    logic        reset_n;
    logic [31:0] d;
    logic [4:0]  w_sel;
    logic        w_en;
    logic [3:0]  w_be;
    logic [4:0]  a_sel;
    logic [4:0]  b_sel;
    logic        rsv_en;
    logic [4:0]  rsv_sel;
    logic        clr;

    logic [31:0] a0, b0, a1, b1;
    logic        ar0, br0, ar1, br1;
    logic [5:0]  pc0, pc1;

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .reset_n(reset_n), .d(d), .w_sel(w_sel), .w_en(w_en),
        .w_be(w_be), .a_sel(a_sel), .b_sel(b_sel), .a(a0), .b(b0),
        .a_ready(ar0), .b_ready(br0), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .clr(clr), .pend_cnt(pc0)
    );

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset_n(reset_n), .d(d), .w_sel(w_sel), .w_en(w_en),
        .w_be(w_be), .a_sel(a_sel), .b_sel(b_sel), .a(a1), .b(b1),
        .a_ready(ar1), .b_ready(br1), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .clr(clr), .pend_cnt(pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [31:0] mreg [32];
    logic [31:0] mpend;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mpend = 32'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] sel, input bit byp);
        logic [31:0] v;
        if (sel == 5'd0) return 32'h0;
        v = mreg[sel];
        if (byp && w_en && w_sel == sel) v = merge(v, d, w_be);
        return v;
    endfunction

    function automatic logic exp_ready(input logic [4:0] sel, input bit byp);
        if (sel == 5'd0) return 1'b1;
        return !mpend[sel] || (byp && w_en && w_sel == sel);
    endfunction

    task automatic model_edge();
        if (clr) begin
            model_clear();
        end else begin
            if (w_en && w_sel != 5'd0) mreg[w_sel] = merge(mreg[w_sel], d, w_be);
            if (w_en) mpend[w_sel] = 1'b0;
            if (rsv_en && rsv_sel != 5'd0) mpend[rsv_sel] = 1'b1;
        end
    endtask

    // Scoreboard
    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;
    sb_t sbq[$];

    task automatic push(input string tag, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic sample(input string tag, input logic [4:0] as, input logic [4:0] bs);
        logic [63:0] obs [9];
        sb_t e;
        a_sel = as;
        b_sel = bs;
        push({tag, ".a"},     64'(exp_data(as, 1'b1)));
        push({tag, ".b"},     64'(exp_data(bs, 1'b1)));
        push({tag, ".ar"},    64'(exp_ready(as, 1'b1)));
        push({tag, ".br"},    64'(exp_ready(bs, 1'b1)));
        push({tag, ".pc"},    64'($countones(mpend)));
        push({tag, ".nb_a"},  64'(exp_data(as, 1'b0)));
        push({tag, ".nb_b"},  64'(exp_data(bs, 1'b0)));
        push({tag, ".nb_ar"}, 64'(exp_ready(as, 1'b0)));
        push({tag, ".nb_pc"}, 64'($countones(mpend)));
        #1;
        obs[0] = 64'(a0);  obs[1] = 64'(b0);  obs[2] = 64'(ar0);
        obs[3] = 64'(br0); obs[4] = 64'(pc0); obs[5] = 64'(a1);
        obs[6] = 64'(b1);  obs[7] = 64'(ar1); obs[8] = 64'(pc1);
        for (int i = 0; i < 9; i++) begin
            if (sbq.size() == 0) begin
                check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check_val(e.tag, obs[i], e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        w_en = 1'b0; w_be = 4'h0; w_sel = 5'd0; d = 32'h0;
        rsv_en = 1'b0; rsv_sel = 5'd0; clr = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
    endtask

    task automatic wr(input logic [4:0] sel, input logic [31:0] data, input logic [3:0] be);
        w_en = 1'b1; w_sel = sel; d = data; w_be = be;
        cycle();
    endtask

    task automatic rsv(input logic [4:0] sel);
        rsv_en = 1'b1; rsv_sel = sel;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        a_sel = 5'd0; b_sel = 5'd0;
        model_clear();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        sample("reset", 5'd3, 5'd8);
        check_val("reset_a_const", 64'(a0), 64'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Full-word writes and dual read
        wr(5'd8, 32'h88888888, 4'hF);
        wr(5'd3, 32'h33333333, 4'hF);
        sample("rd38", 5'd3, 5'd8);
        check_val("rd38_a_const", 64'(a0), 64'h33333333);
        check_val("rd38_b_const", 64'(b0), 64'h88888888);

        // Byte-lane write
        wr(5'd9, 32'h99999999, 4'hF);
        wr(5'd9, 32'h5A5A5A5A, 4'b0101);
        sample("lane", 5'd9, 5'd9);
        check_val("lane_const", 64'(a0), 64'h995A995A);

        // Forwarding: same-cycle visibility only with BYPASS=1
        wr(5'd27, 32'h11111111, 4'hF);
        w_en = 1'b1; w_sel = 5'd27; d = 32'h27272727; w_be = 4'hF;
        sample("byp_pre", 5'd27, 5'd3);
        check_val("byp_const", 64'(a0), 64'h27272727);
        check_val("nobyp_const", 64'(a1), 64'h11111111);
        cycle();
        sample("byp_post", 5'd27, 5'd27);
        w_en = 1'b1; w_sel = 5'd27; d = 32'hA5C3E1F0; w_be = 4'b0110;
        sample("byp_part", 5'd9, 5'd27);
        cycle();
        sample("byp_part_post", 5'd27, 5'd9);

        // Hardwired zero register
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        sample("zero", 5'd0, 5'd0);
        rsv(5'd0);
        sample("zero_rsv", 5'd0, 5'd3);
        check_val("zero_pc_const", 64'(pc0), 64'd0);

        // Reservations
        rsv(5'd5);
        rsv(5'd7);
        sample("rsv57", 5'd5, 5'd7);
        check_val("rsv57_pc_const", 64'(pc0), 64'd2);
        w_en = 1'b1; w_sel = 5'd5; d = 32'h55555555; w_be = 4'hF;
        sample("rdy_byp", 5'd5, 5'd7);
        rsv_en = 1'b1; rsv_sel = 5'd5;
        cycle();
        sample("wr_rsv_same", 5'd5, 5'd7);
        check_val("wr_rsv_same_ar", 64'(ar0), 64'd0);
        rsv(5'd5);
        sample("rsv_again", 5'd5, 5'd5);
        wr(5'd7, 32'h77777777, 4'h0);
        sample("clr7", 5'd7, 5'd5);
        check_val("clr7_pc_const", 64'(pc0), 64'd1);
        w_en = 1'b1; w_sel = 5'd5; d = 32'h0; w_be = 4'h0;
        rsv_en = 1'b1; rsv_sel = 5'd12;
        cycle();
        sample("set_clr", 5'd5, 5'd12);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            w_en    = 1'($urandom_range(0, 1));
            w_sel   = 5'($urandom_range(0, 31));
            d       = $urandom;
            w_be    = 4'($urandom_range(0, 15));
            rsv_en  = 1'($urandom_range(0, 1));
            rsv_sel = 5'($urandom_range(0, 31));
            if (n % 3 == 0) sample("rnd_pre", w_sel, 5'($urandom_range(0, 31)));
            cycle();
            sample("rnd_post", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Mid-cycle asynchronous reset with a write/reservation in flight
        wr(5'd8, 32'h88888888, 4'hF);
        rsv(5'd4);
        w_en = 1'b1; w_sel = 5'd3; d = 32'hDEADBEEF; w_be = 4'hF;
        rsv_en = 1'b1; rsv_sel = 5'd6;
        #2;
        reset_n = 1'b0;
        idle_inputs();
        model_clear();
        sample("async_rst", 5'd8, 5'd4);
        check_val("async_rst_pc_const", 64'(pc0), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        wr(5'd3, 32'h12345678, 4'hF);
        sample("post_rst", 5'd3, 5'd6);

        // Synchronous clear overrides write and reservation
        wr(5'd10, 32'hAAAAAAAA, 4'hF);
        rsv(5'd11);
        clr = 1'b1; w_en = 1'b1; w_sel = 5'd10; d = 32'hFFFFFFFF; w_be = 4'hF;
        rsv_en = 1'b1; rsv_sel = 5'd13;
        cycle();
        sample("clr_a", 5'd10, 5'd3);
        sample("clr_b", 5'd11, 5'd13);
        check_val("clr_const", 64'(a0), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
